// File: rtl/pipe_stage_skid.sv
// Pipeline boundary register with a 2-entry skid buffer.
// in_ready comes straight from a flop, so out_ready has no combinational path to it.
module pipe_stage_skid #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CLR_DATA    = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [1:0]             occupancy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  // State encoding equals the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        main_q, main_d;
  logic [DATA_W-1:0]        skid_q, skid_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [STALL_CNT_W-1:0]   stall_q, stall_d;
  logic                     acc, fire;

  assign acc  = in_valid & in_ready_q;
  assign fire = out_valid_q & out_ready;

  // State, data and output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end

  // Next-state and data steering; flush overrides any accept
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    stall_d = stall_q;

    if (clr) begin
      state_d = EMPTY;
      if (CLR_DATA != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (acc && fire) begin
            main_d = in_data;
          end else if (acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  // Skid entry is only ever valid behind a valid main entry
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ((state_q != FULL) || out_valid_q);
      assert (in_ready_q == (state_q != FULL));
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: instance a (CLR_DATA=1, 16-bit stall counter) and
// instance b (CLR_DATA=0, 3-bit stall counter) share one stimulus stream.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] stall_a;
  logic [2:0]  stall_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CLR_DATA(1), .STALL_CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .occupancy(occ_a), .stall_cnt(stall_a)
  );

  pipe_stage_skid #(.DATA_W(32), .CLR_DATA(0), .STALL_CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .occupancy(occ_b), .stall_cnt(stall_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic [1:0] occ, input logic ov, input logic ir);
    chk({tag, " occ_a"}, 64'(occ_a), 64'(occ));
    chk({tag, " occ_b"}, 64'(occ_b), 64'(occ));
    chk({tag, " out_valid_a"}, 64'(out_valid_a), 64'(ov));
    chk({tag, " out_valid_b"}, 64'(out_valid_b), 64'(ov));
    chk({tag, " in_ready_a"}, 64'(in_ready_a), 64'(ir));
    chk({tag, " in_ready_b"}, 64'(in_ready_b), 64'(ir));
  endtask

  initial begin
    rst_n     = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk_both("reset", 2'd0, 1'b0, 1'b1);
    chk("reset out_data_a", 64'(out_data_a), 64'h0);
    chk("reset stall_a", 64'(stall_a), 64'h0);
    chk("reset stall_b", 64'(stall_b), 64'h0);
    rst_n = 1'b1;
    tick();
    chk_both("post reset", 2'd0, 1'b0, 1'b1);

    // Streaming 1..8 at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(i);
      tick();
      chk_both($sformatf("stream %0d", i), 2'd1, 1'b1, 1'b1);
      chk($sformatf("stream %0d data", i), 64'(out_data_a), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_both("stream drain", 2'd0, 1'b0, 1'b1);
    chk("stream stall_a", 64'(stall_a), 64'h0);

    // Skid fill then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    chk_both("skid A", 2'd1, 1'b1, 1'b1);
    in_data = 32'hB;
    tick();
    chk_both("skid B", 2'd2, 1'b1, 1'b0);
    chk("skid B data", 64'(out_data_a), 64'hA);
    chk("skid stall_a", 64'(stall_a), 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk_both("drain A", 2'd1, 1'b1, 1'b1);
    chk("drain A data", 64'(out_data_a), 64'hB);
    tick();
    chk_both("drain B", 2'd0, 1'b0, 1'b1);
    chk("drain stall_a", 64'(stall_a), 64'd1);

    // Flush from FULL with a competing accept of 0xC
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    chk_both("flush pre", 2'd2, 1'b1, 1'b0);
    clr     = 1'b1;
    in_data = 32'hC;
    tick();
    chk_both("flush", 2'd0, 1'b0, 1'b1);
    chk("flush data_a", 64'(out_data_a), 64'h0);
    chk("flush data_b", 64'(out_data_b), 64'hA);
    chk("flush stall_a", 64'(stall_a), 64'd3);
    chk("flush stall_b", 64'(stall_b), 64'd3);
    clr      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk_both("flush after", 2'd0, 1'b0, 1'b1);
    chk("flush after data_a", 64'(out_data_a), 64'h0);
    chk("flush after data_b", 64'(out_data_b), 64'hA);

    // Flush coinciding with a fire of 0x5
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h5;
    tick();
    chk_both("ffire pre", 2'd1, 1'b1, 1'b1);
    chk("ffire pre data", 64'(out_data_b), 64'h5);
    in_valid = 1'b0;
    clr      = 1'b1;
    tick();
    clr = 1'b0;
    chk_both("ffire", 2'd0, 1'b0, 1'b1);
    chk("ffire data_a", 64'(out_data_a), 64'h0);
    chk("ffire data_b", 64'(out_data_b), 64'h5);
    tick();
    chk_both("ffire after", 2'd0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a cycle with both entries full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    chk_both("areset pre", 2'd2, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk_both("areset", 2'd0, 1'b0, 1'b1);
    chk("areset data_a", 64'(out_data_a), 64'h0);
    chk("areset data_b", 64'(out_data_b), 64'h0);
    chk("areset stall_a", 64'(stall_a), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_both("areset after", 2'd0, 1'b0, 1'b1);

    // Stall saturation: b saturates at 7, a keeps counting
    in_valid = 1'b1;
    in_data  = 32'h7;
    tick();
    in_valid = 1'b0;
    chk("sat start_b", 64'(stall_b), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("sat %0d stall_b", k), 64'(stall_b), 64'((k > 7) ? 7 : k));
      chk($sformatf("sat %0d stall_a", k), 64'(stall_a), 64'(k));
    end
    out_ready = 1'b1;
    tick();
    chk_both("sat drain", 2'd0, 1'b0, 1'b1);
    chk("sat hold_b", 64'(stall_b), 64'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an arbitrary-width payload with a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready purely registered, so there is no combinational path from out_ready back to in_ready.
- Synchronous flush (clr) inserts a bubble; data zeroing on flush is optional.
- Adds occupancy and saturating stall-cycle visibility for the performance counters.

Parameters:
- DATA_W, 32, payload width in bits (packed rd1/rd2/pc/imm/rs/rd fields etc.), legal 1..1024.
- CLR_DATA, 1, 1 = flush and reset zero the data registers; 0 = flush clears valid bits only (data retained).
- STALL_CNT_W, 16, width of the saturating stall counter, legal 1..32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; sampled on clk.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  main entry payload.
- occupancy  out  2  entries held: 0, 1 or 2.
- stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Reset (rst_n=0, async assert, sync deassert):
  - main and skid valids = 0; main and skid data = 0; stall_cnt = 0.
  - Outputs: occupancy = 0, out_valid = 0, out_data = 0, in_ready = 1.
- Handshake events:
  - acc = in_valid & in_ready; fire = out_valid & out_ready.
  - in_data is captured only on acc; a payload is consumed only on fire.
  - in_valid and out_valid must be able to rise without waiting on ready.
- State machine (state = occupancy):
  - EMPTY (in_ready=1, out_valid=0): acc -> ONE, main <= in_data.
  - ONE (in_ready=1, out_valid=1):
    - acc & fire -> ONE, main <= in_data.
    - acc & !fire -> FULL, skid <= in_data.
    - !acc & fire -> EMPTY.
    - else hold.
  - FULL (in_ready=0, out_valid=1): fire -> ONE, main <= skid. Else hold. acc is impossible.
- in_ready = (state != FULL). It is driven from a flop, not from out_ready.
- Latency and ordering:
  - 1 cycle from acc to out_valid when EMPTY.
  - Order strictly FIFO: skid never overtakes main.
  - Sustained throughput is 1 transfer/cycle while out_ready=1.
- out_data always reflects the main data register, including when out_valid=0.
- Flush (clr=1 at edge):
  - Next state is EMPTY: both valids cleared, occupancy = 0, in_ready = 1.
  - clr has priority over acc; a payload presented that cycle is dropped.
  - A fire in the same cycle completes normally, since downstream already took the data.
  - CLR_DATA=1: main and skid data zeroed. CLR_DATA=0: data unchanged.
  - clr while EMPTY is a no-op except for the data zeroing.
- Stall counter:
  - Increments every cycle with out_valid & !out_ready, including the clr cycle.
  - Holds at 2^STALL_CNT_W-1; never wraps.
  - Cleared only by reset.
- Reset mid-transfer: all entries are lost immediately. No partial state survives.
- Invariant (assert in sim): skid valid implies main valid.

Test Plan:
- Streaming: DATA_W=32, out_ready=1, feed 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on consecutive cycles, 1 cycle after each acc; in_ready stays 1; stall_cnt stays 0.
- Skid fill:
  - Stimulus: out_ready=0, send 0xA then 0xB.
  - Required: occupancy 1 then 2; in_ready=0 the cycle after 0xB is accepted.
  - Then raise out_ready: output 0xA then 0xB, and in_ready returns to 1 the cycle after 0xA fires.
- Flush:
  - Stimulus: occupancy=2 (0xA main, 0xB skid); assert clr for 1 cycle while in_valid=1 with 0xC.
  - Required next cycle: occupancy=0, out_valid=0, out_data=0 (CLR_DATA=1); 0xC never appears.
  - Repeat with CLR_DATA=0: out_data stays 0xA with out_valid=0.
- Flush with concurrent fire: occupancy=1 (0x5), out_ready=1, clr=1 same cycle -> 0x5 counted as fired once; next cycle EMPTY.
- Stall saturation: STALL_CNT_W=3, hold out_valid=1 and out_ready=0 for 10 cycles -> stall_cnt counts 1..7 and holds at 7.
- Async reset: assert rst_n=0 mid-cycle with occupancy=2 -> out_valid, occupancy and out_data go to 0 immediately, without waiting for a clock edge; in_ready=1 after deassert.
